// File: rtl/mc_sequencer.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute,
// stalls on memory readiness, halts on ECALL with x17==10 and counts retired instructions.
module mc_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [6:0]       opcode_i,
    input  logic             bcond_i,
    input  logic             halt_req_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_source_o,
    output logic             i_or_d_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic [1:0]       wb_sel_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_signal_o,
    output logic             is_ecall_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EX_ALU, S_WB_ALU, S_ADDR, S_MEM_RD, S_WB_LD,
        S_MEM_WR, S_BR, S_PC4, S_JAL, S_JALR1, S_JALR2, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IF;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
    assign retired_o = retired_q;

    always_comb begin
        state_d         = state_q;
        retire          = 1'b0;
        pc_write_o      = 1'b0;
        pc_source_o     = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        wb_sel_o        = 2'd0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'd0;
        alu_op_signal_o = 2'b00;
        is_ecall_o      = 1'b0;
        halted_o        = 1'b0;

        case (state_q)
            S_IF: begin
                mem_read_o = 1'b1;
                ir_write_o = mem_ready_i;
                if (mem_ready_i) state_d = S_ID;
            end
            S_ID: begin
                alu_src_b_o = 2'd2;
                is_ecall_o  = (opcode_i == OP_SYSTEM);
                case (opcode_i)
                    OP_R, OP_I:        state_d = S_EX_ALU;
                    OP_LOAD, OP_STORE: state_d = S_ADDR;
                    OP_BRANCH:         state_d = S_BR;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_SYSTEM:         state_d = halt_req_i ? S_HALT : S_PC4;
                    default:           state_d = S_PC4;
                endcase
            end
            S_EX_ALU: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = (opcode_i == OP_R) ? 2'd0 : 2'd2;
                alu_op_signal_o = 2'b10;
                state_d         = S_WB_ALU;
            end
            S_WB_ALU, S_WB_LD: begin
                reg_write_o = 1'b1;
                wb_sel_o    = (state_q == S_WB_LD) ? 2'd1 : 2'd0;
                alu_src_b_o = 2'd1;
                pc_write_o  = 1'b1;
                retire      = 1'b1;
                state_d     = S_IF;
            end
            S_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                state_d     = (opcode_i == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
                if (mem_ready_i) state_d = S_WB_LD;
            end
            S_MEM_WR: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
                if (mem_ready_i) begin
                    alu_src_b_o = 2'd1;
                    pc_write_o  = 1'b1;
                    retire      = 1'b1;
                    state_d     = S_IF;
                end
            end
            S_BR: begin
                alu_src_a_o     = 1'b1;
                alu_op_signal_o = 2'b01;
                if (bcond_i) begin
                    pc_write_o  = 1'b1;
                    pc_source_o = 1'b1;
                    retire      = 1'b1;
                    state_d     = S_IF;
                end else begin
                    state_d = S_PC4;
                end
            end
            S_PC4: begin
                alu_src_b_o = 2'd1;
                pc_write_o  = 1'b1;
                retire      = 1'b1;
                state_d     = S_IF;
            end
            S_JALR1: begin
                alu_src_a_o     = 1'b1;
                alu_src_b_o     = 2'd2;
                alu_op_signal_o = 2'b10;
                state_d         = S_JALR2;
            end
            // Link value is PC+4 from the ALU while the target already sits in ALUOut,
            // so rd==rs1 cannot corrupt the jump target.
            S_JAL, S_JALR2: begin
                reg_write_o = 1'b1;
                wb_sel_o    = 2'd2;
                alu_src_b_o = 2'd1;
                pc_write_o  = 1'b1;
                pc_source_o = 1'b1;
                retire      = 1'b1;
                state_d     = S_IF;
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic        clk;
    logic        reset_n;
    logic [6:0]  opcode;
    logic        bcond, halt_req, mem_ready;
    logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0]  wb_sel, alu_src_b, alu_op;
    logic        alu_src_a, is_ecall, halted;
    logic [31:0] retired;

    mc_sequencer #(.CNT_W(32)) dut (
        .clk_i(clk), .reset_ni(reset_n), .opcode_i(opcode), .bcond_i(bcond),
        .halt_req_i(halt_req), .mem_ready_i(mem_ready),
        .pc_write_o(pc_write), .pc_source_o(pc_source), .i_or_d_o(i_or_d),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
        .reg_write_o(reg_write), .wb_sel_o(wb_sel), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .alu_op_signal_o(alu_op), .is_ecall_o(is_ecall),
        .halted_o(halted), .retired_o(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] act;
    assign act = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                  wb_sel, alu_src_a, alu_src_b, alu_op, is_ecall, halted};

    int          vectors = 0;
    int          miscompares = 0;
    logic        chk_en = 1'b0;
    logic [15:0] exp_o = '0;
    logic [31:0] exp_ret = '0;
    logic [31:0] model_ret = '0;
    bit          pending_ret = 1'b0;
    bit          nz = 1'b0;
    string       tag = "";

    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (act !== exp_o || retired !== exp_ret) begin
                miscompares++;
                $display("FAIL %s: ctrl=%04h retired=%0d, required ctrl=%04h retired=%0d",
                         tag, act, retired, exp_o, exp_ret);
            end
        end
    end

    function automatic logic [15:0] cw(bit pcw, bit pcs, bit iod, bit mrd, bit mwr, bit irw,
                                       bit rgw, logic [1:0] wb, bit a, logic [1:0] b,
                                       logic [1:0] op, bit ec, bit hl);
        return {pcw, pcs, iod, mrd, mwr, irw, rgw, wb, a, b, op, ec, hl};
    endfunction

    function automatic logic [15:0] c_fetch(bit rdy); return cw(0,0,0,1,0,rdy,0,2'd0,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [15:0] c_dec(bit ec);    return cw(0,0,0,0,0,0,0,2'd0,0,2'd2,2'd0,ec,0); endfunction
    function automatic logic [15:0] c_pc4();          return cw(1,0,0,0,0,0,0,2'd0,0,2'd1,2'd0,0,0); endfunction
    function automatic logic [15:0] c_wb(logic [1:0] s); return c_pc4() | cw(0,0,0,0,0,0,1,s,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [15:0] c_jump();         return cw(1,1,0,0,0,0,1,2'd2,0,2'd1,2'd0,0,0); endfunction
    function automatic logic [15:0] c_ex(bit rtype);  return cw(0,0,0,0,0,0,0,2'd0,1,rtype ? 2'd0 : 2'd2,2'd2,0,0); endfunction
    function automatic logic [15:0] c_addr();         return cw(0,0,0,0,0,0,0,2'd0,1,2'd2,2'd0,0,0); endfunction
    function automatic logic [15:0] c_jalr1();        return cw(0,0,0,0,0,0,0,2'd0,1,2'd2,2'd2,0,0); endfunction
    function automatic logic [15:0] c_br(bit taken);  return cw(taken,taken,0,0,0,0,0,2'd0,1,2'd0,2'd1,0,0); endfunction
    function automatic logic [15:0] c_mrd();          return cw(0,0,1,1,0,0,0,2'd0,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [15:0] c_mwr();          return cw(0,0,1,0,1,0,0,2'd0,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [15:0] c_halt();         return cw(0,0,0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1); endfunction

    task automatic step(input logic [6:0] op, input logic bc, input logic hr, input logic mr,
                        input logic [15:0] e, input bit ret, input string nm);
        @(posedge clk);
        #1;
        if (pending_ret) model_ret = model_ret + 32'd1;
        pending_ret = ret;
        opcode = op; bcond = bc; halt_req = hr; mem_ready = mr;
        exp_o = e; exp_ret = model_ret; tag = nm; chk_en = 1'b1;
    endtask

    task automatic exec(input logic [6:0] op, input int if_w, input int mem_w,
                        input logic bc, input logic hr, input string nm);
        for (int i = 0; i < if_w; i++) step(op, bc, hr, 1'b0, c_fetch(1'b0), 1'b0, {nm, "_ifwait"});
        step(op, bc, hr, 1'b1, c_fetch(1'b1), 1'b0, {nm, "_if"});
        nz = ~nz;
        step(op, bc, hr, nz, c_dec(op == OP_SYSTEM), 1'b0, {nm, "_id"});
        nz = ~nz;
        case (op)
            OP_R, OP_I: begin
                step(op, bc, hr, nz, c_ex(op == OP_R), 1'b0, {nm, "_ex"});
                step(op, bc, hr, ~nz, c_wb(2'd0), 1'b1, {nm, "_wb"});
            end
            OP_LOAD: begin
                step(op, bc, hr, nz, c_addr(), 1'b0, {nm, "_addr"});
                for (int i = 0; i < mem_w; i++) step(op, bc, hr, 1'b0, c_mrd(), 1'b0, {nm, "_rdwait"});
                step(op, bc, hr, 1'b1, c_mrd(), 1'b0, {nm, "_rd"});
                step(op, bc, hr, nz, c_wb(2'd1), 1'b1, {nm, "_wbld"});
            end
            OP_STORE: begin
                step(op, bc, hr, nz, c_addr(), 1'b0, {nm, "_addr"});
                for (int i = 0; i < mem_w; i++) step(op, bc, hr, 1'b0, c_mwr(), 1'b0, {nm, "_wrwait"});
                step(op, bc, hr, 1'b1, c_mwr() | c_pc4(), 1'b1, {nm, "_wr"});
            end
            OP_BRANCH: begin
                step(op, bc, hr, nz, c_br(bc), bc, {nm, "_br"});
                if (!bc) step(op, bc, hr, ~nz, c_pc4(), 1'b1, {nm, "_pc4"});
            end
            OP_JAL: step(op, bc, hr, nz, c_jump(), 1'b1, {nm, "_jal"});
            OP_JALR: begin
                step(op, bc, hr, nz, c_jalr1(), 1'b0, {nm, "_jalr1"});
                step(op, bc, hr, ~nz, c_jump(), 1'b1, {nm, "_jalr2"});
            end
            OP_SYSTEM: if (!hr) step(op, bc, hr, nz, c_pc4(), 1'b1, {nm, "_pc4"});
            default: step(op, bc, hr, nz, c_pc4(), 1'b1, {nm, "_nop"});
        endcase
    endtask

    task automatic reset_mid(input string nm);
        @(posedge clk);
        #3;
        mem_ready = 1'b0;
        reset_n = 1'b0;
        model_ret = '0; pending_ret = 1'b0;
        exp_o = 16'h1000; exp_ret = '0; tag = nm;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; opcode = '0; bcond = 1'b0; halt_req = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (act !== 16'h1000 || retired !== 32'd0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ctrl=%04h retired=%0d halted=%b, required ctrl=1000 retired=0 halted=0",
                     act, retired, halted);
        end
        reset_n = 1'b1;

        step(OP_R, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, "reset_if_idle");
        step(OP_R, 1'b0, 1'b0, 1'b1, 16'h1400, 1'b0, "add_if_lit");
        step(OP_R, 1'b0, 1'b0, 1'b1, 16'h0020, 1'b0, "add_id_lit");
        step(OP_R, 1'b0, 1'b0, 1'b1, 16'h0048, 1'b0, "add_ex_lit");
        step(OP_R, 1'b0, 1'b0, 1'b1, 16'h8210, 1'b1, "add_wb_lit");

        exec(OP_I,      0, 0, 1'b1, 1'b1, "addi");
        exec(OP_LOAD,   1, 3, 1'b0, 1'b0, "lw");
        exec(OP_STORE,  0, 2, 1'b1, 1'b0, "sw");
        exec(OP_BRANCH, 0, 0, 1'b1, 1'b0, "beq_t");
        exec(OP_BRANCH, 0, 0, 1'b0, 1'b0, "beq_nt");
        exec(OP_JAL,    0, 0, 1'b0, 1'b0, "jal");
        exec(OP_JALR,   2, 0, 1'b1, 1'b1, "jalr");
        exec(OP_SYSTEM, 0, 0, 1'b0, 1'b0, "ecall_nohalt");
        exec(7'h7F,     0, 0, 1'b1, 1'b0, "undef_nop");

        exec(OP_SYSTEM, 0, 0, 1'b0, 1'b1, "ecall_halt");
        for (int i = 0; i < 20; i++) begin
            nz = ~nz;
            step(OP_R, nz, nz, ~nz, c_halt(), 1'b0, "halt_sticky");
        end
        @(negedge clk);
        #1;
        vectors++;
        if (halted !== 1'b1 || retired !== model_ret) begin
            miscompares++;
            $display("FAIL halt_wait_expired: halted=%b retired=%0d, required halted=1 retired=%0d",
                     halted, retired, model_ret);
        end
        reset_mid("reset_in_halt");

        exec(OP_JAL, 0, 0, 1'b0, 1'b0, "jal_after_reset");
        exec(OP_STORE, 0, 0, 1'b0, 1'b0, "sw_fast");
        step(OP_STORE, 1'b0, 1'b0, 1'b1, c_fetch(1'b1), 1'b0, "sw2_if");
        step(OP_STORE, 1'b0, 1'b0, 1'b0, c_dec(1'b0), 1'b0, "sw2_id");
        step(OP_STORE, 1'b0, 1'b0, 1'b1, c_addr(), 1'b0, "sw2_addr");
        step(OP_STORE, 1'b0, 1'b0, 1'b0, c_mwr(), 1'b0, "sw2_wrwait");
        reset_mid("reset_in_mem_wr");

        exec(OP_R, 0, 0, 1'b0, 1'b0, "add_after_reset");
        step(OP_R, 1'b0, 1'b0, 1'b0, c_fetch(1'b0), 1'b0, "final_retired");
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences PC, IR, MDR, ALUOut, register file and unified memory each cycle.
- Drives the 2-bit ALU-op class that the ALU control decoder expands into a concrete ALU operation.
- Also stalls on memory readiness, detects the halting ECALL and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (state cleared while low)
- opcode  input  7  IR[6:0] (valid from ID onward)
- bcond  input  1  ALU branch-compare result, combinational, valid in S_BR
- halt_req  input  1  x17==10 from register file read port
- mem_ready  input  1  memory completed current access this cycle
- pc_write  output  1  PC load enable
- pc_source  output  1  0=ALU result, 1=ALUOut register
- i_or_d  output  1  memory address: 0=PC, 1=ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load enable
- reg_write  output  1  register file write enable
- wb_sel  output  2  0=ALUOut, 1=MDR, 2=ALU result
- alu_src_a  output  1  0=PC, 1=A register
- alu_src_b  output  2  0=B register, 1=constant 4, 2=immediate
- alu_op_signal  output  2  00=add, 01=branch compare, 10=decode from funct/opcode, 11=reserved (never driven)
- is_ecall  output  1  ECALL decoded in ID
- halted  output  1  sticky halt indication
- retired  output  CNT_W  retired-instruction count

Behaviour:
- Outputs are combinational from state, opcode, bcond and mem_ready.
- Every output defaults to 0 in any state that does not assert it.
- Reset low: state=S_IF, retired=0, halted=0. Release takes effect at the next clk edge.
- Reset asserted mid-instruction aborts immediately and returns to S_IF.
- S_IF: mem_read=1, i_or_d=0. ir_write = mem_ready. Stay while !mem_ready; go to S_ID on mem_ready.
- S_ID: alu_src_a=0, alu_src_b=2, alu_op_signal=00 (ALUOut <= PC+imm). is_ecall = (opcode==1110011).
  - Next state by opcode:
    - R (0110011) or I (0010011) -> S_EX_ALU
    - LOAD / STORE -> S_ADDR
    - BRANCH -> S_BR
    - JAL -> S_JAL
    - JALR -> S_JALR1
    - ECALL with halt_req -> S_HALT
    - ECALL without halt_req -> S_PC4
    - any other opcode -> S_PC4 (NOP)
- S_EX_ALU: alu_src_a=1, alu_src_b = 0 for R-type, 2 for I-type, alu_op_signal=10 -> S_WB_ALU.
- S_WB_ALU: reg_write=1, wb_sel=0. PC <= PC+4 (alu_src_a=0, alu_src_b=1, op 00, pc_source=0, pc_write=1). Retire; -> S_IF.
- S_ADDR: alu_src_a=1, alu_src_b=2, op 00. LOAD -> S_MEM_RD; STORE -> S_MEM_WR.
- S_MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then -> S_WB_LD.
- S_WB_LD: reg_write=1, wb_sel=1, PC+4 as in S_WB_ALU. Retire; -> S_IF.
- S_MEM_WR: mem_write=1, i_or_d=1. On mem_ready: PC+4 update, retire, -> S_IF. Otherwise hold.
- S_BR: alu_src_a=1, alu_src_b=0, op 01.
  - bcond=1: pc_write=1, pc_source=1, retire, -> S_IF.
  - bcond=0: -> S_PC4.
- S_PC4: PC+4 update, retire, -> S_IF.
- S_JAL: reg_write=1, wb_sel=2 (PC+4 via a=0, b=1, op 00), pc_write=1, pc_source=1. Retire; -> S_IF.
- S_JALR1: alu_src_a=1, alu_src_b=2, op 10 (ALUOut <= rs1+imm) -> S_JALR2.
- S_JALR2: reg_write=1, wb_sel=2 (PC+4), pc_write=1, pc_source=1. Retire; -> S_IF. The rs1==rd case is safe because the target is already held in ALUOut.
- S_HALT: absorbing, halted=1, all enables 0. Only reset exits.
- Retire = retired+1 on the clock edge of any transition into S_IF from a non-reset state. The count wraps modulo 2^CNT_W. A halting ECALL does not retire.
- mem_ready outside S_IF, S_MEM_RD and S_MEM_WR is ignored.

Test Plan:
- ADD x3,x1,x2 with mem_ready always 1 -> states IF, ID, EX_ALU, WB_ALU. alu_op_signal 00, 00, 10, 00. reg_write only in cycle 4. retired 0->1.
- LW with mem_ready low for 3 cycles in S_MEM_RD -> FSM holds, mem_read=1, i_or_d=1 throughout. reg_write with wb_sel=1 one cycle after mem_ready. Total 5+3 cycles.
- BEQ: bcond=1 -> pc_write with pc_source=1 in S_BR, 3 cycles. bcond=0 -> extra S_PC4 cycle with pc_source=0, 4 cycles.
- JALR x1, 0(x1) -> S_JALR1 then S_JALR2. PC loaded from ALUOut; x1 gets the old PC+4.
- ECALL with halt_req=1 -> S_HALT, halted=1 sticky for 20 cycles, no enables, retired unchanged. Same ECALL with halt_req=0 -> S_PC4, retired+1.
- Reset driven low during S_MEM_WR with mem_ready=0 -> mem_write drops asynchronously, state S_IF, retired=0. Undefined opcode 0x7F -> S_PC4 NOP.
